// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: smooths gain changes for an audio output stage.
//
// A requested gain code is ramped toward in fixed STEP increments, one increment per
// audio sample tick, so the output never sees a discontinuous gain jump. A level mute
// input ramps the gain down to zero and, on release, ramps back up to the last
// accepted target.
//
// Ports:
//   clk_48       in   sample-domain clock
//   reset_n      in   asynchronous active-low reset
//   sample_en    in   one-cycle tick per audio sample
//   target_gain  in   requested gain code, unsigned Q4.12
//   target_valid in   request strobe for target_gain
//   target_ready out  a new target can be accepted this cycle
//   mute         in   level; ramp the gain to 0 while high
//   gain         out  registered gain code for the output gain stage
//   ramping      out  gain has not yet reached its current destination
//   done         out  one-cycle pulse when a target ramp completes
//   muted        out  muted and gain has reached 0
module gain_ramp_ctrl #(
   parameter logic [15:0] STEP  = 16'd16,
   parameter logic [15:0] UNITY = 16'h1000
) (
   input  logic        clk_48,
   input  logic        reset_n,
   input  logic        sample_en,
   input  logic [15:0] target_gain,
   input  logic        target_valid,
   output logic        target_ready,
   input  logic        mute,
   output logic [15:0] gain,
   output logic        ramping,
   output logic        done,
   output logic        muted
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRamp = 2'd1,
      StMute = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] gain_q, gain_d;
   logic [15:0] hold_tgt_q, hold_tgt_d;
   logic        done_q, done_d;
   logic        muted_q, muted_d;

   // One ramp step from cur toward dst. The distance is taken at 17 bits so the
   // comparison against STEP is exact; stepping by STEP only happens when the
   // distance exceeds STEP, so the result can neither overshoot nor wrap.
   function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                               input logic [15:0] dst);
      logic [16:0] diff;
      if (dst >= cur) begin
         diff = {1'b0, dst} - {1'b0, cur};
      end else begin
         diff = {1'b0, cur} - {1'b0, dst};
      end
      if (diff <= {1'b0, STEP}) begin
         return dst;
      end else if (dst > cur) begin
         return cur + STEP;
      end else begin
         return cur - STEP;
      end
   endfunction

   assign target_ready = (state_q == StIdle) && !mute;

   always_comb begin
      state_d    = state_q;
      gain_d     = gain_q;
      hold_tgt_d = hold_tgt_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Mute wins over a simultaneous request; the request is dropped.
            if (mute) begin
               state_d = StMute;
               if (sample_en) begin
                  gain_d = step_toward(gain_q, 16'h0000);
               end
            end else if (target_valid) begin
               hold_tgt_d = target_gain;
               if (target_gain != gain_q) begin
                  state_d = StRamp;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         StRamp: begin
            // Muting abandons the ramp without a done pulse; hold_tgt is kept.
            if (mute) begin
               state_d = StMute;
               if (sample_en) begin
                  gain_d = step_toward(gain_q, 16'h0000);
               end
            end else if (sample_en) begin
               gain_d = step_toward(gain_q, hold_tgt_q);
               if (gain_d == hold_tgt_q) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end

         StMute: begin
            // On release the step taken on the same edge already heads for hold_tgt.
            if (!mute) begin
               state_d = StRamp;
               if (sample_en) begin
                  gain_d = step_toward(gain_q, hold_tgt_q);
                  if (gain_d == hold_tgt_q) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end else if (sample_en) begin
               gain_d = step_toward(gain_q, 16'h0000);
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      muted_d = (state_d == StMute) && (gain_d == 16'h0000);
   end

   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         gain_q     <= UNITY;
         hold_tgt_q <= UNITY;
         done_q     <= 1'b0;
         muted_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gain_q     <= gain_d;
         hold_tgt_q <= hold_tgt_d;
         done_q     <= done_d;
         muted_q    <= muted_d;
      end
   end

   assign gain    = gain_q;
   assign done    = done_q;
   assign muted   = muted_q;
   assign ramping = (state_q == StRamp) || ((state_q == StMute) && (gain_q != 16'h0000));

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
module tb_gain_ramp_ctrl;

   logic        clk_48;
   logic        reset_n;
   logic        sample_en;
   logic [15:0] target_gain;
   logic        target_valid;
   logic        target_ready;
   logic        mute;
   logic [15:0] gain;
   logic        ramping;
   logic        done;
   logic        muted;

   int checks = 0;
   int errors = 0;

   gain_ramp_ctrl #(
      .STEP (16'd16),
      .UNITY(16'h1000)
   ) dut (
      .clk_48      (clk_48),
      .reset_n     (reset_n),
      .sample_en   (sample_en),
      .target_gain (target_gain),
      .target_valid(target_valid),
      .target_ready(target_ready),
      .mute        (mute),
      .gain        (gain),
      .ramping     (ramping),
      .done        (done),
      .muted       (muted)
   );

   initial clk_48 = 1'b0;
   always #5 clk_48 = ~clk_48;

   typedef struct {
      logic        se;
      logic        tv;
      logic [15:0] tg;
      logic        mu;
      logic [15:0] e_gain;
      logic        e_ready;
      logic        e_ramp;
      logic        e_done;
      logic        e_muted;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs, take one clock edge, sample #1 after it.
   task automatic cyc(input logic se, input logic tv, input logic [15:0] tg, input logic mu);
      sample_en    = se;
      target_valid = tv;
      target_gain  = tg;
      mute         = mu;
      @(posedge clk_48);
      #1;
   endtask

   task automatic do_reset();
      sample_en    = 1'b0;
      target_valid = 1'b0;
      target_gain  = 16'h0000;
      mute         = 1'b0;
      reset_n      = 1'b0;
      repeat (2) @(posedge clk_48);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int done_cnt;
      int done_tick;
      int ticks;
      int bad;
      logic [15:0] mgain;
      logic        se;

      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 16'h1008, 1'b0, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1008, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1008, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 16'h1008, 1'b0, 16'h1008, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1008, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 16'h0400, 1'b1, 16'h1008, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0ff8, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0ff8, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1008, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1008, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state.
      do_reset();
      chk("rst_gain", 32'(gain), 32'h1000);
      chk("rst_ready", 32'(target_ready), 32'h1);
      chk("rst_ramping", 32'(ramping), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_muted", 32'(muted), 32'h0);

      // Table: idle, single-step target, equal target, mute-vs-request, unmute.
      for (int i = 0; i < 13; i++) begin
         cyc(vecs[i].se, vecs[i].tv, vecs[i].tg, vecs[i].mu);
         chk($sformatf("vec%0d_gain", i), 32'(gain), 32'(vecs[i].e_gain));
         chk($sformatf("vec%0d_ready", i), 32'(target_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_ramping", i), 32'(ramping), 32'(vecs[i].e_ramp));
         chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
         chk($sformatf("vec%0d_muted", i), 32'(muted), 32'(vecs[i].e_muted));
      end

      // Ramp 0x1000 -> 0x2000 with a tick every cycle: 256 ticks.
      do_reset();
      cyc(1'b1, 1'b1, 16'h2000, 1'b0);
      done_cnt  = 0;
      done_tick = -1;
      for (int i = 1; i <= 300; i++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b0);
         if (i == 1) chk("up_first_step", 32'(gain), 32'h1010);
         if (done) begin
            done_cnt++;
            done_tick = i;
         end
      end
      chk("up_done_tick", 32'(done_tick), 32'd256);
      chk("up_done_cnt", 32'(done_cnt), 32'd1);
      chk("up_final_gain", 32'(gain), 32'h2000);
      chk("up_ready", 32'(target_ready), 32'h1);

      // Ramp 0x1000 -> 0x0800 with ticks gated 1-in-4: 128 downward steps.
      do_reset();
      cyc(1'b0, 1'b1, 16'h0800, 1'b0);
      mgain    = 16'h1000;
      bad      = 0;
      ticks    = 0;
      done_cnt = 0;
      done_tick = -1;
      for (int c = 0; c < 600; c++) begin
         se = ((c % 4) == 3);
         cyc(se, 1'b0, 16'h0000, 1'b0);
         if (se && mgain != 16'h0800) begin
            mgain = mgain - 16'd16;
            ticks++;
         end
         if (gain !== mgain) bad++;
         if (done) begin
            done_cnt++;
            done_tick = ticks;
         end
      end
      chk("dn_gated_track", 32'(bad), 32'd0);
      chk("dn_done_ticks", 32'(done_tick), 32'd128);
      chk("dn_done_cnt", 32'(done_cnt), 32'd1);
      chk("dn_final_gain", 32'(gain), 32'h0800);

      // Mute mid-ramp at 0x1800, ramp to 0, then release back to 0x2000.
      do_reset();
      cyc(1'b0, 1'b1, 16'h2000, 1'b0);
      for (int i = 0; i < 128; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("mu_start_gain", 32'(gain), 32'h1800);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      chk("mu_hold_gain", 32'(gain), 32'h1800);
      chk("mu_ready", 32'(target_ready), 32'h0);
      done_cnt = 0;
      done_tick = -1;
      for (int i = 1; i <= 500; i++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b1);
         if (done) done_cnt++;
         if (muted && done_tick < 0) done_tick = i;
      end
      chk("mu_zero_ticks", 32'(done_tick), 32'd384);
      chk("mu_no_done", 32'(done_cnt), 32'd0);
      chk("mu_gain_zero", 32'(gain), 32'h0000);
      chk("mu_muted", 32'(muted), 32'h1);
      chk("mu_ready_low", 32'(target_ready), 32'h0);
      chk("mu_ramping_low", 32'(ramping), 32'h0);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("unmu_ramping", 32'(ramping), 32'h1);
      chk("unmu_muted", 32'(muted), 32'h0);
      done_cnt = 0;
      done_tick = -1;
      for (int i = 1; i <= 600; i++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b0);
         if (done) begin
            done_cnt++;
            done_tick = i;
         end
      end
      chk("unmu_done_tick", 32'(done_tick), 32'd512);
      chk("unmu_done_cnt", 32'(done_cnt), 32'd1);
      chk("unmu_gain", 32'(gain), 32'h2000);

      // Asynchronous reset between edges in the middle of a ramp.
      do_reset();
      cyc(1'b0, 1'b1, 16'h2000, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("ar_pre_gain", 32'(gain), 32'h10a0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_gain", 32'(gain), 32'h1000);
      chk("ar_ramping", 32'(ramping), 32'h0);
      chk("ar_done", 32'(done), 32'h0);
      @(negedge clk_48);
      reset_n = 1'b1;
      done_cnt = 0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b0);
         if (done) done_cnt++;
         if (gain !== 16'h1000) bad++;
      end
      chk("ar_no_done", 32'(done_cnt), 32'd0);
      chk("ar_gain_held", 32'(bad), 32'd0);
      chk("ar_ready", 32'(target_ready), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
